sdram_arbiter: RTL and testbench

- Sequences the shared SDRAM between four command sources: power-up init, auto-refresh, image-write (UART/SD picture loader) and frame-read (VGA fetch).
- Owns the refresh interval timer, grants one source at a time, and muxes the granted source's command, bank and address onto the SDRAM pins.
- Sits between the sdram_init/aref/write/read sub-controllers and the top-level sdram_* ports.

---
 rtl/sdram_arbiter.sv | 134 +++++++++++++
 tb/tb_sdram_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Shared SDRAM sequencer: owns the refresh timer, grants init/refresh/write/read
// one at a time and muxes the granted source onto the SDRAM pins.
module sdram_arbiter #(
  parameter int REF_CYCLES = 750,
  parameter int CNT_W      = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] aref_addr,
  input  logic        aref_end,
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_dq_oe,
  input  logic        wr_end,
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  input  logic        rd_end,
  output logic        aref_req,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ} state_t;

  localparam logic [3:0]       CMD_NOP  = 4'b0111;
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ref_cnt;
  logic             ref_wrap;
  logic             aref_clr;
  logic             last_wr;   // 1: last data grant was WRITE
  logic [3:0]       cmd;

  assign ref_wrap = (state != INIT) && (ref_cnt == REF_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= INIT;
      ref_cnt  <= '0;
      aref_req <= 1'b0;
      last_wr  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT || ref_wrap) ref_cnt <= '0;
      else                           ref_cnt <= ref_cnt + 1'b1;
      // a wrap on the same cycle as the grant re-arms the request
      if (ref_wrap)      aref_req <= 1'b1;
      else if (aref_clr) aref_req <= 1'b0;
      if (state == ARBIT && state_nxt == WRITE)     last_wr <= 1'b1;
      else if (state == ARBIT && state_nxt == READ) last_wr <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    aref_clr  = 1'b0;
    case (state)
      INIT:  if (init_end) state_nxt = ARBIT;
      ARBIT: begin
        if (aref_req) begin
          state_nxt = AREF;
          aref_clr  = 1'b1;
        end else if (wr_req && rd_req) state_nxt = last_wr ? READ : WRITE;
        else if (wr_req)               state_nxt = WRITE;
        else if (rd_req)               state_nxt = READ;
      end
      AREF:  if (aref_end) state_nxt = ARBIT;
      WRITE: if (wr_end)   state_nxt = ARBIT;
      READ:  if (rd_end)   state_nxt = ARBIT;
      default: state_nxt = INIT;
    endcase
  end

  assign aref_en   = (state == AREF);
  assign wr_en     = (state == WRITE);
  assign rd_en     = (state == READ);
  assign sdram_cke = 1'b1;

  always_comb begin
    cmd          = CMD_NOP;
    sdram_ba     = '0;
    sdram_addr   = '0;
    sdram_dq_out = '0;
    sdram_dq_oe  = 1'b0;
    case (state)
      INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd        = aref_cmd;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd          = wr_cmd;
        sdram_ba     = wr_ba;
        sdram_addr   = wr_addr;
        sdram_dq_out = wr_data;
        sdram_dq_oe  = wr_dq_oe;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter against a cycle-level behavioural model
// with short refresh interval and scripted sub-controller responses.
module tb_sdram_arbiter;
  localparam int REF = 20;
  localparam int S_INIT = 0, S_ARB = 1, S_AREF = 2, S_WR = 3, S_RD = 4;

  logic        sys_clk = 0, sys_rst = 1;
  logic        init_end = 0;
  logic [3:0]  init_cmd = 0, aref_cmd = 0, wr_cmd = 0, rd_cmd = 0;
  logic [1:0]  init_ba = 0, wr_ba = 0, rd_ba = 0;
  logic [12:0] init_addr = 0, aref_addr = 0, wr_addr = 0, rd_addr = 0;
  logic [15:0] wr_data = 0;
  logic        aref_end = 0, wr_req = 0, wr_dq_oe = 0, wr_end = 0, rd_req = 0, rd_end = 0;
  logic        aref_req, aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_dq_oe;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [15:0] sdram_dq_out;

  sdram_arbiter #(.REF_CYCLES(REF), .CNT_W(5)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
    .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_end(aref_end),
    .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_dq_oe(wr_dq_oe), .wr_end(wr_end),
    .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr), .rd_end(rd_end),
    .aref_req(aref_req), .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
    .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0, n_pass = 0;
  int m_st = S_INIT, m_cnt = 0, left = 0, n_wr = 0, n_rd = 0, n_ar = 0;
  bit m_areq = 0, m_lastwr = 0, known = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [63:0] exp_bus();
    logic [3:0] c; logic [1:0] b; logic [12:0] a; logic [15:0] d; logic oe;
    c = 4'b0111; b = 0; a = 0; d = 0; oe = 0;
    if (m_st == S_INIT) begin c = init_cmd; b = init_ba; a = init_addr; end
    if (m_st == S_AREF) begin c = aref_cmd; a = aref_addr; end
    if (m_st == S_WR)   begin c = wr_cmd; b = wr_ba; a = wr_addr; d = wr_data; oe = wr_dq_oe; end
    if (m_st == S_RD)   begin c = rd_cmd; b = rd_ba; a = rd_addr; end
    return {28'd0, 1'b1, c, b, a, d, oe};
  endfunction

  // mode 0: no requests, 1: both requests held + fixed write data, 2: random
  // ie: -1 random init_end, else forced value
  task automatic cycle(input int mode, input bit rst, input int ie);
    int nx; bit clr;
    @(negedge sys_clk);
    sys_rst = rst;
    {init_cmd, init_ba, init_addr} = 19'($urandom);
    {aref_cmd, aref_addr} = 17'($urandom);
    {wr_cmd, wr_ba, wr_addr} = 19'($urandom);
    {rd_cmd, rd_ba, rd_addr} = 19'($urandom);
    if (ie < 0) init_end = (m_st == S_INIT) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
    else        init_end = 1'(ie);
    if (mode == 1) begin wr_data = 16'hA5C3; wr_dq_oe = 1; wr_req = 1; rd_req = 1; end
    else begin
      wr_data = 16'($urandom); wr_dq_oe = 1'($urandom);
      wr_req = (mode == 2) && ($urandom_range(0, 2) != 0);
      rd_req = (mode == 2) && ($urandom_range(0, 2) != 0);
    end
    // write/read finish early once refresh is pending
    if ((m_st == S_WR || m_st == S_RD) && m_areq && left > 2) left = 2;
    aref_end = (m_st == S_AREF) ? (left == 0) : ($urandom_range(0, 9) == 0);
    wr_end   = (m_st == S_WR)   ? (left == 0) : ($urandom_range(0, 9) == 0);
    rd_end   = (m_st == S_RD)   ? (left == 0) : ($urandom_range(0, 9) == 0);
    if (left > 0) left--;
    #1;
    if (known) begin
      chk("ctl", {60'd0, aref_req, aref_en, wr_en, rd_en},
          {60'd0, m_areq, m_st == S_AREF, m_st == S_WR, m_st == S_RD});
      chk("bus", {28'd0, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
                  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe}, exp_bus());
    end
    nx = m_st; clr = 0;
    case (m_st)
      S_INIT: if (init_end) nx = S_ARB;
      S_ARB: if (m_areq) begin nx = S_AREF; clr = 1; end
             else if (wr_req && rd_req) nx = m_lastwr ? S_RD : S_WR;
             else if (wr_req) nx = S_WR;
             else if (rd_req) nx = S_RD;
      S_AREF: if (aref_end) nx = S_ARB;
      S_WR:   if (wr_end) nx = S_ARB;
      default: if (rd_end) nx = S_ARB;
    endcase
    @(posedge sys_clk);
    if (rst) begin
      m_st = S_INIT; m_cnt = 0; m_areq = 0; m_lastwr = 0; known = 1; left = 0;
    end else begin
      if (m_st != S_INIT && m_cnt == REF - 1) m_areq = 1;
      else if (clr) m_areq = 0;
      m_cnt = (m_st == S_INIT) ? 0 : (m_cnt + 1) % REF;
      if (m_st == S_ARB && nx == S_WR) begin m_lastwr = 1; n_wr++; end
      if (m_st == S_ARB && nx == S_RD) begin m_lastwr = 0; n_rd++; end
      if (m_st == S_ARB && nx == S_AREF) n_ar++;
      if (nx != m_st && nx == S_AREF) left = 7;
      else if (nx != m_st && (nx == S_WR || nx == S_RD)) left = $urandom_range(0, 5);
      m_st = nx;
    end
  endtask

  initial begin
    int guard;
    repeat (3) cycle(0, 1, 0);
    repeat (7) cycle(0, 0, 0);
    cycle(0, 0, 1);
    repeat (70)  cycle(0, 0, -1);
    repeat (150) cycle(1, 0, -1);
    repeat (2500) cycle(2, 0, -1);
    guard = 0;
    while (m_st != S_RD && guard < 500) begin cycle(2, 0, -1); guard++; end
    chk("reach_read", {63'd0, m_st == S_RD}, 64'd1);
    cycle(2, 1, -1);
    repeat (30) cycle(2, 0, 0);
    cycle(2, 0, 1);
    repeat (300) cycle(2, 0, -1);
    chk("saw_grants", {61'd0, n_wr > 0, n_rd > 0, n_ar > 0}, 64'd7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
